// File: rtl/keyboard_ps2_receiver.sv
// PS/2 keyboard receive path: pin synchronizer, frame FSM with inter-edge
// watchdog, framing check and a first-word fall-through scancode FIFO.
// Optional build macro: KEYBOARD_PS2_RX_PARITY_CHECK_EN enables odd-parity
// checking; without it only the stop bit decides whether a frame is good.

module keyboard_synchronizer #(
    parameter int P_N = 2
) (
    input  logic           iCLOCK,
    input  logic           inRESET,
    input  logic           iRESET_SYNC,
    input  logic [P_N-1:0] iDATA,
    output logic [P_N-1:0] oDATA
);
    logic [P_N-1:0] r_meta;
    logic [P_N-1:0] r_sync;

    // Two-flop synchronizer for asynchronous pin levels
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_meta <= '0;
            r_sync <= '0;
        end else if (iRESET_SYNC) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= iDATA;
            r_sync <= r_meta;
        end
    end

    assign oDATA = r_sync;
endmodule

module keyboard_ps2_receiver #(
    parameter int P_FIFO_DEPTH = 16,
    parameter int P_FIFO_AW    = 4,
    parameter int P_TIMEOUT    = 50000
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic               iRESET_SYNC,
    input  logic               iPS2_CLK,
    input  logic               iPS2_DATA,
    output logic               oRD_VALID,
    output logic [7:0]         oRD_DATA,
    input  logic               iRD_REQ,
    output logic [P_FIFO_AW:0] oFIFO_COUNT,
    output logic               oERR_FRAME,
    output logic               oERR_OVERFLOW
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    localparam int WD_W = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;
    localparam logic [WD_W-1:0]    WD_MAX   = WD_W'(P_TIMEOUT - 1);
    localparam logic [P_FIFO_AW:0] FULL_CNT = (P_FIFO_AW + 1)'(P_FIFO_DEPTH);

    logic [1:0]           w_sync;      // [1] = PS/2 clock, [0] = PS/2 data
    logic                 w_fall;
    logic                 w_par_ok;
    logic                 w_good;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_timeout;

    logic [1:0]           r_state;
    logic [3:0]           r_bitcnt;
    logic [WD_W-1:0]      r_wd;
    logic                 r_clk_prev;
    logic [9:0]           r_shift;     // d0..d7, parity, stop after a full frame
    logic [7:0]           r_mem [P_FIFO_DEPTH];
    logic [P_FIFO_AW-1:0] r_wptr;
    logic [P_FIFO_AW-1:0] r_rptr;
    logic [P_FIFO_AW:0]   r_count;

    keyboard_synchronizer #(
        .P_N(2)
    ) u_sync (
        .iCLOCK     (iCLOCK),
        .inRESET    (inRESET),
        .iRESET_SYNC(iRESET_SYNC),
        .iDATA      ({iPS2_CLK, iPS2_DATA}),
        .oDATA      (w_sync)
    );

    assign w_fall = r_clk_prev & ~w_sync[1];

`ifdef KEYBOARD_PS2_RX_PARITY_CHECK_EN
    assign w_par_ok = ^r_shift[8:0];
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_good    = r_shift[9] & w_par_ok;
    assign w_full    = (r_count == FULL_CNT);
    assign oRD_VALID = (r_count != '0);
    assign w_pop     = iRD_REQ & oRD_VALID;
    assign w_push    = (r_state == S_CHECK) & w_good & (~w_full | w_pop);
    assign w_timeout = (r_state == S_RECV) & ~w_fall & (r_wd == WD_MAX);

    assign oERR_FRAME    = ((r_state == S_CHECK) & ~w_good) | w_timeout;
    assign oERR_OVERFLOW = (r_state == S_CHECK) & w_good & w_full & ~w_pop;
    assign oRD_DATA      = oRD_VALID ? r_mem[r_rptr] : 8'h00;
    assign oFIFO_COUNT   = r_count;

    // Frame sequencing: start detect, bit counting and inter-edge watchdog
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state    <= S_IDLE;
            r_bitcnt   <= '0;
            r_wd       <= '0;
            r_clk_prev <= 1'b0;
        end else if (iRESET_SYNC) begin
            r_state    <= S_IDLE;
            r_bitcnt   <= '0;
            r_wd       <= '0;
            r_clk_prev <= 1'b0;
        end else begin
            r_clk_prev <= w_sync[1];
            case (r_state)
                S_IDLE: begin
                    if (w_fall && !w_sync[0]) begin
                        r_state  <= S_RECV;
                        r_bitcnt <= '0;
                        r_wd     <= '0;
                    end
                end
                S_RECV: begin
                    if (w_fall) begin
                        r_wd <= '0;
                        if (r_bitcnt == 4'd9) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end else if (r_wd == WD_MAX) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Serial shift register, LSB first; content is only trusted in CHECK
    always_ff @(posedge iCLOCK) begin
        if (r_state == S_RECV && w_fall) begin
            r_shift <= {w_sync[0], r_shift[9:1]};
        end
    end

    // FIFO storage write; pointers below decide what is visible
    always_ff @(posedge iCLOCK) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_shift[7:0];
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (iRESET_SYNC) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
